cosine_vec_loader: RTL and testbench
====================================

// Module: cosine_vec_loader
// PURPOSE
//  Upstream feeder for the cosine-similarity engine. Accepts vector pairs as a serial
//  stream (one A/B element pair per beat) and zero-pads short vectors. Presents the W-wide
//  parallel vectors to the engine and pulses its start. Waits for the engine's valid, with
//  a timeout, and returns the similarity on a valid/ready result channel.
//  Data are IEEE-754 single-precision bit patterns; no arithmetic is done here.
// PARAMETERS
//  W        5    elements per vector (>=1); must match the engine's W
//  TIMEOUT  64   max WAIT cycles for engine valid before result is forced (>=2)
// PORTS
//  clk            in   1        clock, all logic on posedge
//  rst            in   1        synchronous, active-high reset
//  in_valid       in   1        input beat valid
//  in_ready       out  1        input beat accepted when in_valid&&in_ready
//  in_a           in   32       element of vector A
//  in_b           in   32       element of vector B
//  in_last        in   1        beat is the last element of this pair
//  cs_start       out  1        one-cycle start pulse to engine
//  cs_vec_a       out  W*32     vector A, element i at [32*i +: 32]
//  cs_vec_b       out  W*32     vector B, same packing
//  cs_valid       in   1        engine result valid
//  cs_similarity  in   32       engine result
//  res_valid      out  1        result available
//  res_ready      in   1        result consumed when res_valid&&res_ready
//  res_data       out  32       captured similarity (or NaN on timeout)
//  res_len        out  $clog2(W+1)  number of real elements in the pair
//  res_timeout    out  1        result was forced by timeout
// BEHAVIOUR
//  Reset (rst=1 at posedge):
//   - state=FILL, count=0, timer=0.
//   - cs_vec_a/b=0, cs_start=0, res_valid=0, res_data=0, res_len=0, res_timeout=0.
//   - in_ready=0 while rst is high.
//   - Reset applies from any state. An in-flight engine result is dropped.
//  FSM FILL -> ISSUE -> WAIT -> RESULT -> FILL. Outputs are Moore, registered.
//  FILL:
//   - in_ready=1.
//   - On each handshake: element[count] <= in_a/in_b; count++.
//   - Vector closes on in_last or on beat index W-1, whichever comes first.
//     Overlong input auto-closes at W; no error is flagged.
//   - On close: res_len <= count+1 and the FSM moves to ISSUE.
//  ISSUE:
//   - cs_start=1 for exactly this one cycle, i.e. the cycle after the closing beat.
//   - Next state WAIT, timer <= 0.
//  WAIT:
//   - On cs_valid: res_data <= cs_similarity, res_timeout <= 0; move to RESULT.
//   - Else timer++. When timer reaches TIMEOUT-1: res_data <= 32'h7FC00000,
//     res_timeout <= 1; move to RESULT.
//   - cs_valid is ignored in every state except WAIT.
//  RESULT:
//   - res_valid=1. res_data, res_len and res_timeout are held stable until handshake.
//   - On res_valid&&res_ready: clear cs_vec_a/b to 0, count <= 0; move to FILL.
//   - in_ready=1 the following cycle.
//  cs_vec_a/b only change in FILL (writes and clears). They are stable from ISSUE until
//  the RESULT handshake.
//  Zero padding: elements count..W-1 stay 32'h0 (+0.0), so the dot product and norms are
//  unaffected.
//  in_ready=0 outside FILL. Beats offered then are not consumed and must be held by the
//  source.
// TESTING (W=5, TIMEOUT=64)
//  1. Full vectors: 5 beats, a=b=32'h3F800000, in_last on beat 5.
//     -> cs_start single pulse the next cycle; all cs_vec elements 3F800000.
//     -> Engine returns 3F800000: res_data=3F800000, res_len=5, res_timeout=0.
//  2. Single element: a=40400000 (3.0), b=C0400000 (-3.0), in_last.
//     -> element 0 set, elements 1..4 =0; res_len=1.
//  3. Overlong: 7 beats, no in_last.
//     -> auto-close after beat 5; in_ready=0 for beats 6-7 until the result handshake.
//     -> res_len=5.
//  4. Timeout: cs_valid never asserted.
//     -> res_valid rises 1 cycle after timer hits 63; res_data=7FC00000, res_timeout=1.
//  5. Backpressure: res_ready low for 10 cycles.
//     -> res_valid/res_data/res_len stable, in_ready=0, late cs_valid ignored.
//     -> Then accept: cs_vec=0 and in_ready=1 next cycle.
//  6. rst in WAIT.
//     -> next cycle: FILL, cs_vec=0, res_valid=0.
//     -> cs_valid arriving afterwards produces no result.

Source files
------------

// File: rtl/cosine_vec_loader.sv
// Serial-to-parallel feeder for the cosine-similarity engine: gathers A/B element pairs,
// zero-pads short vectors, starts the engine and returns its result (or a NaN on timeout).
module cosine_vec_loader #(
    parameter int W       = 5,
    parameter int TIMEOUT = 64,
    localparam int LW     = $clog2(W + 1),
    localparam int TW     = $clog2(TIMEOUT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_a,
    input  logic [31:0]       in_b,
    input  logic              in_last,
    output logic              cs_start,
    output logic [W*32-1:0]   cs_vec_a,
    output logic [W*32-1:0]   cs_vec_b,
    input  logic              cs_valid,
    input  logic [31:0]       cs_similarity,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [31:0]       res_data,
    output logic [LW-1:0]     res_len,
    output logic              res_timeout,
    output logic [1:0]        dbg_state
);

    // Handshakes: a beat (or result) transfers on a rising clk edge where valid && ready.
    // The source must hold a beat stable while valid && !ready.
    typedef enum logic [1:0] {
        S_FILL   = 2'd0,
        S_ISSUE  = 2'd1,
        S_WAIT   = 2'd2,
        S_RESULT = 2'd3
    } state_t;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    state_t            state_q;
    logic [LW-1:0]     count_q;
    logic [TW-1:0]     timer_q;
    logic [W*32-1:0]   vec_a_q;
    logic [W*32-1:0]   vec_b_q;
    logic              cs_start_q;
    logic              res_valid_q;
    logic [31:0]       res_data_q;
    logic [LW-1:0]     res_len_q;
    logic              res_timeout_q;

    logic              fill_hs;
    logic              fill_close;

    // in_ready is a state decode gated by rst so it drops during the reset cycle itself.
    assign in_ready   = (state_q == S_FILL) && !rst;
    assign fill_hs    = in_valid && in_ready;
    assign fill_close = in_last || (count_q == LW'(W - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_FILL;
            count_q       <= '0;
            timer_q       <= '0;
            vec_a_q       <= '0;
            vec_b_q       <= '0;
            cs_start_q    <= 1'b0;
            res_valid_q   <= 1'b0;
            res_data_q    <= '0;
            res_len_q     <= '0;
            res_timeout_q <= 1'b0;
        end else begin
            cs_start_q <= 1'b0;
            case (state_q)
                S_FILL: begin
                    if (fill_hs) begin
                        vec_a_q[32*count_q +: 32] <= in_a;
                        vec_b_q[32*count_q +: 32] <= in_b;
                        count_q <= count_q + LW'(1);
                        if (fill_close) begin
                            res_len_q  <= count_q + LW'(1);
                            cs_start_q <= 1'b1;
                            state_q    <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    timer_q <= '0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (cs_valid) begin
                        res_data_q    <= cs_similarity;
                        res_timeout_q <= 1'b0;
                        res_valid_q   <= 1'b1;
                        state_q       <= S_RESULT;
                    end else if (timer_q == TW'(TIMEOUT - 1)) begin
                        res_data_q    <= QNAN;
                        res_timeout_q <= 1'b1;
                        res_valid_q   <= 1'b1;
                        state_q       <= S_RESULT;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                S_RESULT: begin
                    // Padding relies on the vectors being all-zero when FILL resumes.
                    if (res_ready) begin
                        vec_a_q     <= '0;
                        vec_b_q     <= '0;
                        count_q     <= '0;
                        res_valid_q <= 1'b0;
                        state_q     <= S_FILL;
                    end
                end
                default: state_q <= S_FILL;
            endcase
        end
    end

    assign cs_start    = cs_start_q;
    assign cs_vec_a    = vec_a_q;
    assign cs_vec_b    = vec_b_q;
    assign res_valid   = res_valid_q;
    assign res_data    = res_data_q;
    assign res_len     = res_len_q;
    assign res_timeout = res_timeout_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_cosine_vec_loader.sv
// Self-checking bench for cosine_vec_loader: directed scenarios followed by randomized
// transactions, each checked against a pair-level reference model.
module tb_cosine_vec_loader;

    localparam int W       = 5;
    localparam int TIMEOUT = 64;
    localparam int LW      = $clog2(W + 1);
    localparam int CW      = W * 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_a;
    logic [31:0]     in_b;
    logic            in_last;
    logic            cs_start;
    logic [CW-1:0]   cs_vec_a;
    logic [CW-1:0]   cs_vec_b;
    logic            cs_valid;
    logic [31:0]     cs_similarity;
    logic            res_valid;
    logic            res_ready;
    logic [31:0]     res_data;
    logic [LW-1:0]   res_len;
    logic            res_timeout;
    logic [1:0]      dbg_state;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] exp_q[$];
    logic [31:0] qa[$];
    logic [31:0] qb[$];
    logic        ql[$];

    logic [CW-1:0] mdl_a;
    logic [CW-1:0] mdl_b;
    int            mdl_n;

    always #5 clk = ~clk;

    cosine_vec_loader #(.W(W), .TIMEOUT(TIMEOUT)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_a          (in_a),
        .in_b          (in_b),
        .in_last       (in_last),
        .cs_start      (cs_start),
        .cs_vec_a      (cs_vec_a),
        .cs_vec_b      (cs_vec_b),
        .cs_valid      (cs_valid),
        .cs_similarity (cs_similarity),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_data      (res_data),
        .res_len       (res_len),
        .res_timeout   (res_timeout),
        .dbg_state     (dbg_state)
    );

    task automatic check(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Build a beat stream; last_pos < 0 means no beat carries in_last.
    task automatic build(input int nb, input int last_pos, input bit rnd,
                         input logic [31:0] va, input logic [31:0] vb);
        qa.delete(); qb.delete(); ql.delete();
        for (int i = 0; i < nb; i++) begin
            qa.push_back(rnd ? 32'($urandom) : va);
            qb.push_back(rnd ? 32'($urandom) : vb);
            ql.push_back(i == last_pos);
        end
    endtask

    // Reference: a pair takes beats up to the first in_last or the W-th beat; the rest is +0.0.
    task automatic model_pair();
        mdl_a = '0;
        mdl_b = '0;
        mdl_n = 0;
        for (int i = 0; i < qa.size(); i++) begin
            mdl_a[32*i +: 32] = qa[i];
            mdl_b[32*i +: 32] = qb[i];
            if (ql[i] || i == W - 1) begin
                mdl_n = i + 1;
                break;
            end
        end
    endtask

    // Offers beats (with random idle gaps) until the model's pair length is consumed.
    task automatic drive_fill(input bit gaps);
        int  acc;
        int  guard;
        bit  hs;
        acc   = 0;
        guard = 0;
        while (acc < mdl_n && guard < 60) begin
            in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            in_a     = qa[acc];
            in_b     = qb[acc];
            in_last  = ql[acc];
            @(negedge clk);
            hs = in_valid && in_ready;
            @(posedge clk); #1;
            if (hs) acc++;
            guard++;
        end
        check("fill_accepted", CW'(acc), CW'(mdl_n));
        if (qa.size() > acc) begin
            in_valid = 1'b1;
            in_a     = qa[acc];
            in_b     = qb[acc];
            in_last  = ql[acc];
        end else begin
            in_valid = 1'b0;
        end
    endtask

    // d: WAIT cycle (0-based) at which the engine answers, <0 for never.
    // rd: cycles res_ready stays low. noise: spurious cs_valid outside WAIT.
    task automatic run_txn(input int d, input int rd, input logic [31:0] sim, input bit noise,
                           input bit gaps);
        logic [31:0] ed;
        logic        et;
        int          rise;
        int          cyc;
        int          got_rise;
        bit          bad_ready;
        bit          unstable;
        model_pair();
        et   = !(d >= 0 && d < TIMEOUT);
        ed   = et ? 32'h7FC0_0000 : sim;
        rise = et ? TIMEOUT + 1 : d + 2;
        exp_q.push_back(ed);
        drive_fill(gaps);

        cyc       = 0;
        got_rise  = -1;
        bad_ready = 1'b0;
        while (cyc < 200) begin
            cs_valid      = (d >= 0 && cyc == d + 1);
            cs_similarity = cs_valid ? sim : 32'($urandom);
            if (noise && cyc == 0) begin
                cs_valid      = 1'b1;
                cs_similarity = 32'hDEAD_BEEF;
            end
            @(negedge clk);
            if (cyc == 0) begin
                check("start_pulse", CW'(cs_start), CW'(1));
                check("vec_a_issue", cs_vec_a, mdl_a);
                check("vec_b_issue", cs_vec_b, mdl_b);
            end
            if (cyc == 1) check("start_single", CW'(cs_start), CW'(0));
            if (in_ready) bad_ready = 1'b1;
            if (res_valid) begin
                got_rise = cyc;
                break;
            end
            @(posedge clk); #1;
            cyc++;
        end
        if (got_rise < 0) $display("FAIL result_wait: got no res_valid within 200 cycles required cycle %0d", rise);
        check("result_cycle", CW'(got_rise), CW'(rise));
        check("res_data", CW'(res_data), CW'(exp_q.pop_front()));
        check("res_len", CW'(res_len), CW'(mdl_n));
        check("res_timeout", CW'(res_timeout), CW'(et));
        check("vec_a_held", cs_vec_a, mdl_a);
        check("ready_low_busy", CW'(bad_ready), CW'(0));

        unstable = 1'b0;
        for (int k = 0; k < rd; k++) begin
            @(posedge clk); #1;
            cs_valid      = noise;
            cs_similarity = 32'($urandom);
            @(negedge clk);
            if (!res_valid || res_data !== ed || res_len !== LW'(mdl_n) || res_timeout !== et ||
                in_ready || cs_vec_a !== mdl_a || cs_vec_b !== mdl_b)
                unstable = 1'b1;
        end
        check("hold_stable", CW'(unstable), CW'(0));

        @(posedge clk); #1;
        cs_valid  = 1'b0;
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        in_valid  = 1'b0;
        @(negedge clk);
        check("post_res_valid", CW'(res_valid), CW'(0));
        check("post_in_ready", CW'(in_ready), CW'(1));
        check("post_vec_a", cs_vec_a, '0);
        check("post_vec_b", cs_vec_b, '0);
        @(posedge clk); #1;
    endtask

    initial begin
        int nb;
        int lp;
        int d;
        int r;
        rst           = 1'b1;
        in_valid      = 1'b0;
        in_a          = '0;
        in_b          = '0;
        in_last       = 1'b0;
        cs_valid      = 1'b0;
        cs_similarity = '0;
        res_ready     = 1'b0;

        // Reset block
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", CW'(in_ready), CW'(0));
        check("rst_res_valid", CW'(res_valid), CW'(0));
        check("rst_cs_start", CW'(cs_start), CW'(0));
        check("rst_vec_a", cs_vec_a, '0);
        check("rst_vec_b", cs_vec_b, '0);
        check("rst_res_data", CW'(res_data), CW'(0));
        check("rst_res_len", CW'(res_len), CW'(0));
        check("rst_res_timeout", CW'(res_timeout), CW'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_release_ready", CW'(in_ready), CW'(1));
        @(posedge clk); #1;

        // Full, single-element, overlong, timeout, backpressure with late engine valid
        build(5, 4, 1'b0, 32'h3F80_0000, 32'h3F80_0000);
        run_txn(3, 0, 32'h3F80_0000, 1'b0, 1'b0);
        build(1, 0, 1'b0, 32'h4040_0000, 32'hC040_0000);
        run_txn(0, 1, 32'h3F00_0000, 1'b0, 1'b0);
        build(7, -1, 1'b1, '0, '0);
        run_txn(5, 2, 32'h3E80_0000, 1'b0, 1'b0);
        build(2, 1, 1'b1, '0, '0);
        run_txn(-1, 0, 32'h0, 1'b0, 1'b0);
        build(3, 2, 1'b1, '0, '0);
        run_txn(2, 10, 32'h3F40_0000, 1'b1, 1'b0);

        // Reset while waiting on the engine drops the pair
        build(2, 1, 1'b1, '0, '0);
        model_pair();
        drive_fill(1'b0);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("wait_rst_ready", CW'(in_ready), CW'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("wait_rst_in_ready", CW'(in_ready), CW'(1));
        check("wait_rst_res_valid", CW'(res_valid), CW'(0));
        check("wait_rst_vec_a", cs_vec_a, '0);
        check("wait_rst_vec_b", cs_vec_b, '0);
        @(posedge clk); #1;
        cs_valid      = 1'b1;
        cs_similarity = 32'h3F80_0000;
        @(posedge clk); #1;
        cs_valid = 1'b0;
        begin
            bit spurious;
            spurious = 1'b0;
            for (int k = 0; k < 6; k++) begin
                @(negedge clk);
                if (res_valid || !in_ready) spurious = 1'b1;
                @(posedge clk); #1;
            end
            check("wait_rst_no_result", CW'(spurious), CW'(0));
        end

        // Randomized pairs
        for (int t = 0; t < 25; t++) begin
            nb = $urandom_range(1, 8);
            lp = $urandom_range(0, nb);
            if (lp == nb) begin
                lp = -1;
                if (nb < W) nb = W + $urandom_range(0, 2);
            end
            build(nb, lp, 1'b1, '0, '0);
            r = $urandom_range(0, 9);
            if (r <= 6)      d = $urandom_range(0, 10);
            else if (r == 7) d = TIMEOUT - 1;
            else if (r == 8) d = -1;
            else             d = TIMEOUT + $urandom_range(0, 5);
            run_txn(d, $urandom_range(0, 4), 32'($urandom), 1'($urandom_range(0, 1)), 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
